// File: rtl/dmem_if.sv
// Data-port bundle between the core (master) and the data-memory responder (slave).
interface dmem_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        ack;
  logic [31:0] rdata;
  logic        err;
  logic        busy;

  modport master (output req, we, addr, wdata, be, input ack, rdata, err, busy);
  modport slave  (input req, we, addr, wdata, be, output ack, rdata, err, busy);
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data memory answering core load/store requests after a fixed
// number of wait states, with byte-lane stores and an error response.
module dmem_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic  clk,
  input  logic  rst_n,
  dmem_if.slave bus
);
  localparam int         IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] mem [DEPTH];

  logic             commit_s;
  logic             bad_s;
  logic             mem_we_s;
  logic             cur_we_s;
  logic [31:0]      cur_addr_s;
  logic [31:0]      cur_wdata_s;
  logic [3:0]       cur_be_s;
  logic [IDX_W-1:0] idx_s;

  // With zero wait states the access commits on the sampling edge, so use the live bus.
  always_comb begin
    if (state_q == ST_IDLE) begin
      cur_we_s    = bus.we;
      cur_addr_s  = bus.addr;
      cur_wdata_s = bus.wdata;
      cur_be_s    = bus.be;
    end else begin
      cur_we_s    = we_q;
      cur_addr_s  = addr_q;
      cur_wdata_s = wdata_q;
      cur_be_s    = be_q;
    end
  end

  assign idx_s = cur_addr_s[IDX_W+1:2];
  assign bad_s = (cur_addr_s[1:0] != 2'b00) || ({2'b00, cur_addr_s[31:2]} >= 32'(DEPTH));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    commit_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          we_d    = bus.we;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          be_d    = bus.be;
          cnt_d   = WAIT_INIT;
          if (WAIT_INIT == 4'd0) begin
            state_d  = ST_RESP;
            commit_s = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // <= rather than == so a corrupted zero count cannot strand the FSM.
        if (cnt_q <= 4'd1) begin
          state_d  = ST_RESP;
          cnt_d    = 4'd0;
          commit_s = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ack_d    = commit_s;
    err_d    = 1'b0;
    rdata_d  = 32'h0000_0000;
    mem_we_s = 1'b0;
    if (commit_s) begin
      if (bad_s) begin
        err_d = 1'b1;
      end else if (cur_we_s) begin
        mem_we_s = 1'b1;
      end else begin
        rdata_d = mem[idx_s];
      end
    end else begin
      rdata_d = 32'h0000_0000;
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0000_0000;
      wdata_q <= 32'h0000_0000;
      be_q    <= 4'h0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage is deliberately not reset; rst_n only blocks a commit while held low.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_we_s && rst_n && cur_be_s[i]) begin
        mem[idx_s][8*i +: 8] <= cur_wdata_s[8*i +: 8];
      end
    end
  end

  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;
  assign bus.busy  = busy_q;
endmodule
